// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared EX-stage types for the iterative divider
package cpu_pkg;

   localparam logic [3:0] DIV_TYPE = 4'd2;

   typedef enum logic [1:0] {
      DIV_W  = 2'd0,
      MOD_W  = 2'd1,
      DIV_WU = 2'd2,
      MOD_WU = 2'd3
   } div_sub_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_e;

   function automatic logic sub_is_signed(input div_sub_e s);
      return (s == DIV_W) || (s == MOD_W);
   endfunction

   function automatic logic sub_is_mod(input div_sub_e s);
      return (s == MOD_W) || (s == MOD_WU);
   endfunction

endpackage

// File: rtl/div_iter_step.sv
// rtl/div_iter_step.sv - one restoring-division step (shift in dividend bit, trial subtract)
module div_iter_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             dvd_msb,
   input  logic [WIDTH-1:0] dvs,
   output logic [WIDTH-1:0] rem_next,
   output logic             q_bit
);

   // The shifted partial remainder can reach 2*dvs-1, so the trial needs one extra bit.
   logic [WIDTH:0] trial;
   logic [WIDTH:0] diff;

   assign trial    = {rem, dvd_msb};
   assign diff     = trial - {1'b0, dvs};
   assign q_bit    = ~diff[WIDTH];
   assign rem_next = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];

endmodule

// File: rtl/div_iter_ctrl.sv
// rtl/div_iter_ctrl.sv - multi-cycle signed/unsigned divider with sequencing FSM
module div_iter_ctrl
   import cpu_pkg::*;
#(
   parameter int         WIDTH    = 32,
   parameter logic [3:0] TYPE_DIV = DIV_TYPE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] rrj,
   input  logic [WIDTH-1:0] rrk,
   input  logic [31:0]      ctr,
   input  logic             flush,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] divresult
);

   localparam int CW = $clog2(WIDTH) + 1;

   div_state_e       state;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH-1:0] rem;
   logic [CW-1:0]    cnt;
   logic             q_neg;
   logic             r_neg;
   logic             op_mod;

   logic [4:0]       subtype;
   div_sub_e         sub;
   logic             sub_signed;
   logic             accept;
   logic [WIDTH-1:0] mag_j;
   logic [WIDTH-1:0] mag_k;
   logic [WIDTH-1:0] rem_next;
   logic             q_bit;
   logic [WIDTH-1:0] quo_fix;
   logic [WIDTH-1:0] rem_fix;
   logic             ctr_unused;

   assign subtype    = ctr[11:7];
   assign sub        = div_sub_e'(subtype[1:0]);
   assign sub_signed = sub_is_signed(sub);
   assign accept     = in_valid & in_ready & (ctr[3:0] == TYPE_DIV) & (subtype[4:2] == 3'd0);
   assign ctr_unused = ^{ctr[31:12], ctr[6:4]};

   assign mag_j = (sub_signed & rrj[WIDTH-1]) ? -rrj : rrj;
   assign mag_k = (sub_signed & rrk[WIDTH-1]) ? -rrk : rrk;

   // dvd doubles as the quotient register: dividend bits shift out the top, q bits in the bottom.
   assign quo_fix = q_neg ? -dvd : dvd;
   assign rem_fix = r_neg ? -rem : rem;

   div_iter_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem),
      .dvd_msb  (dvd[WIDTH-1]),
      .dvs      (dvs),
      .rem_next (rem_next),
      .q_bit    (q_bit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         divresult <= '0;
         dvd       <= '0;
         dvs       <= '0;
         rem       <= '0;
         cnt       <= '0;
         q_neg     <= 1'b0;
         r_neg     <= 1'b0;
         op_mod    <= 1'b0;
      end else if (flush) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  dvd      <= mag_j;
                  dvs      <= mag_k;
                  rem      <= '0;
                  q_neg    <= sub_signed & (rrj[WIDTH-1] ^ rrk[WIDTH-1]);
                  r_neg    <= sub_signed & rrj[WIDTH-1];
                  op_mod   <= sub_is_mod(sub);
                  in_ready <= 1'b0;
                  if (rrk == '0) begin
                     // Divide by zero skips iteration: all-ones quotient, raw dividend remainder.
                     state     <= DONE;
                     out_valid <= 1'b1;
                     divresult <= sub_is_mod(sub) ? rrj : '1;
                  end else begin
                     state <= CALC;
                     busy  <= 1'b1;
                     cnt   <= CW'(WIDTH - 1);
                  end
               end
            end
            CALC: begin
               rem <= rem_next;
               dvd <= {dvd[WIDTH-2:0], q_bit};
               cnt <= cnt - 1'b1;
               if (cnt == '0) begin
                  state <= FIX;
               end
            end
            FIX: begin
               divresult <= op_mod ? rem_fix : quo_fix;
               state     <= DONE;
               busy      <= 1'b0;
               out_valid <= 1'b1;
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_iter_ctrl.sv
// tb/tb_div_iter_ctrl.sv - scoreboard bench for div_iter_ctrl
module tb_div_iter_ctrl;

   localparam logic [4:0] S_DIVW  = 5'd0;
   localparam logic [4:0] S_MODW  = 5'd1;
   localparam logic [4:0] S_DIVWU = 5'd2;
   localparam logic [4:0] S_MODWU = 5'd3;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] rrj;
   logic [31:0] rrk;
   logic [31:0] ctr;
   logic        flush;
   logic        busy;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] divresult;

   typedef struct {
      logic [31:0] val;
      int          lat;
      int          acc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   logic ov_prev = 1'b0;

   div_iter_ctrl #(.WIDTH(32), .TYPE_DIV(4'd2)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .rrj       (rrj),
      .rrk       (rrk),
      .ctr       (ctr),
      .flush     (flush),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .divresult (divresult)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mk_ctr(input logic [3:0] typ, input logic [4:0] sub);
      return {20'd0, sub, 3'd0, typ};
   endfunction

   // Monitor: one scoreboard entry per rising out_valid.
   always @(negedge clk) begin
      exp_t e;
      if (out_valid && !ov_prev) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("divresult", divresult, e.val);
            chk("latency", 32'(cyc - e.acc), 32'(e.lat));
         end
      end
      ov_prev = out_valid;
   end

   task automatic issue(input logic [4:0] sub, input logic [31:0] j, input logic [31:0] k,
                        input logic [31:0] exp_val, input int exp_lat, input bit track);
      int n;
      exp_t e;
      @(negedge clk);
      in_valid = 1'b1;
      ctr      = mk_ctr(4'd2, sub);
      rrj      = j;
      rrk      = k;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("accept_timeout", {31'd0, in_ready}, 32'd1);
      if (track) begin
         e.val = exp_val;
         e.lat = exp_lat;
         e.acc = cyc;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_empty();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) chk("result_timeout", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
   endtask

   task automatic wait_out_valid();
      int n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) chk("out_valid_timeout", {31'd0, out_valid}, 32'd1);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      rrj       = '0;
      rrk       = '0;
      ctr       = '0;
      flush     = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_divresult", divresult, 32'd0);
      rst = 1'b0;

      issue(S_DIVW,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 1'b1); wait_empty();
      issue(S_MODW,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 1'b1); wait_empty();
      issue(S_MODWU, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 34, 1'b1); wait_empty();
      issue(S_DIVW,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, 1'b1); wait_empty();
      issue(S_MODW,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34, 1'b1); wait_empty();
      issue(S_DIVW,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 1'b1); wait_empty();
      issue(S_MODW,  32'd7, 32'hFFFF_FFFE, 32'd1, 34, 1'b1); wait_empty();
      issue(S_DIVWU, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 34, 1'b1); wait_empty();
      issue(S_MODWU, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 34, 1'b1); wait_empty();
      chk("hold_in_idle", divresult, 32'h7FFF_FFFF);

      // Divide by zero with the consumer stalled.
      out_ready = 1'b0;
      issue(S_DIVWU, 32'd1234, 32'd0, 32'hFFFF_FFFF, 1, 1'b1);
      wait_out_valid();
      repeat (3) begin
         @(negedge clk);
         chk("dz_in_ready_low", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      wait_empty();
      issue(S_MODWU, 32'd1234, 32'd0, 32'd1234, 1, 1'b1); wait_empty();

      // Unrecognised control words must not be accepted.
      @(negedge clk);
      in_valid = 1'b1;
      rrj      = 32'd50;
      rrk      = 32'd5;
      ctr      = mk_ctr(4'd3, S_DIVW);
      repeat (3) @(negedge clk);
      chk("bad_type_busy", {31'd0, busy}, 32'd0);
      chk("bad_type_in_ready", {31'd0, in_ready}, 32'd1);
      ctr = mk_ctr(4'd2, 5'd5);
      repeat (3) @(negedge clk);
      chk("bad_sub_busy", {31'd0, busy}, 32'd0);
      in_valid = 1'b0;

      // Flush in CALC discards the op; the next one still computes correctly.
      issue(S_DIVWU, 32'd100, 32'd7, 32'd0, 0, 1'b0);
      repeat (10) @(negedge clk);
      chk("pre_flush_busy", {31'd0, busy}, 32'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_busy", {31'd0, busy}, 32'd0);
      chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
      repeat (40) @(negedge clk);
      chk("flush_no_out", {31'd0, out_valid}, 32'd0);
      issue(S_DIVWU, 32'd100, 32'd7, 32'd14, 34, 1'b1); wait_empty();

      // Flush together with in_valid in IDLE: no accept.
      @(negedge clk);
      in_valid = 1'b1;
      ctr      = mk_ctr(4'd2, S_DIVW);
      flush    = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      flush    = 1'b0;
      chk("flush_idle_busy", {31'd0, busy}, 32'd0);
      repeat (2) @(negedge clk);
      chk("flush_idle_no_out", {31'd0, out_valid}, 32'd0);

      // Consumer stall in DONE: result stable, new requests ignored.
      out_ready = 1'b0;
      issue(S_MODWU, 32'd100, 32'd7, 32'd2, 34, 1'b1);
      wait_out_valid();
      in_valid = 1'b1;
      rrj      = 32'd9;
      rrk      = 32'd3;
      ctr      = mk_ctr(4'd2, S_DIVWU);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
         chk("stall_divresult", divresult, 32'd2);
         chk("stall_busy", {31'd0, busy}, 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_empty();
      chk("post_stall_in_ready", {31'd0, in_ready}, 32'd1);

      // Asynchronous reset in the middle of CALC.
      issue(S_DIVW, 32'd1000, 32'd3, 32'd0, 0, 1'b0);
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("arst_divresult", divresult, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      chk("arst_no_out", {31'd0, out_valid}, 32'd0);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
